axi_sram_slave: RTL and testbench

//  AXI3/AXI4 responder on the slave side of axi_intf; bridges AXI bursts to a single-port synchronous SRAM.

---
 rtl/axi_sram_slave_if.sv | 76 +++++++
 rtl/axi_sram_slave.sv | 198 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// axi_intf: AXI3/AXI4 channel bundle shared by masters and slaves.
//   AW/W/B : write address, write data, write response
//   AR/R   : read address, read data
//   modport master drives valids/payloads; modport slave drives readys/responses.
interface axi_intf #(
    parameter int ID_WIDTH   = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI slave bridging one burst at a time onto a single-port
// synchronous SRAM (read data returned one cycle after the access).
//   clk, rst    : clock, synchronous active-high reset
//   s           : AXI slave port (axi_intf.slave)
//   sram_cs     : chip select, one access per cycle
//   sram_we     : byte write enables (all zero = read)
//   sram_addr   : word address
//   sram_wdata  : write data
//   sram_rdata  : read data, valid the cycle after a read access
module axi_sram_slave #(
    parameter int ID_WIDTH       = 10,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_intf.slave                    s,
    output logic                      sram_cs,
    output logic [DATA_WIDTH/8-1:0]   sram_we,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_wdata,
    input  logic [DATA_WIDTH-1:0]     sram_rdata
);
    localparam int LB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE, AW_ACC, WR, WRESP, AR_ACC, RD_REQ, RD_DATA
    } state_t;

    state_t                  state, state_nxt;
    logic                    prio_wr;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [7:0]              len_q, cnt;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rd_fresh;
    logic                    go_wr, go_rd, last;
    logic [ADDR_WIDTH-1:0]   incr, wmask;

    // Sideband fields this target does not act on.
    logic unused_sideband;
    assign unused_sideband = ^{s.awlock, s.awcache, s.awprot, s.arlock, s.arcache,
                               s.arprot, s.wid, s.wlast};

    // Round-robin: on contention prio_wr selects the write channel.
    assign go_wr = s.awvalid && (!s.arvalid || prio_wr);
    assign go_rd = s.arvalid && (!s.awvalid || !prio_wr);
    assign last  = (cnt == len_q);

    always_comb begin
        incr  = ONE << size_q;
        wmask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wmask) | ((addr_q + incr) & wmask);
            default: addr_nxt = addr_q + incr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio_wr  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
            rdata_q  <= '0;
            rd_fresh <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_fresh <= (state == RD_REQ);
            if (rd_fresh)
                rdata_q <= sram_rdata;
            case (state)
                IDLE: begin
                    if (go_rd)
                        prio_wr <= 1'b1;
                    else if (go_wr)
                        prio_wr <= 1'b0;
                end
                AW_ACC: begin
                    id_q    <= s.awid;
                    addr_q  <= s.awaddr;
                    len_q   <= s.awlen;
                    size_q  <= s.awsize;
                    burst_q <= s.awburst;
                    cnt     <= '0;
                    err_q   <= (s.awburst == 2'b11) || (int'(s.awsize) > LB);
                end
                AR_ACC: begin
                    id_q    <= s.arid;
                    addr_q  <= s.araddr;
                    len_q   <= s.arlen;
                    size_q  <= s.arsize;
                    burst_q <= s.arburst;
                    cnt     <= '0;
                    err_q   <= (s.arburst == 2'b11) || (int'(s.arsize) > LB);
                end
                WR: begin
                    if (s.wvalid && !last) begin
                        cnt    <= cnt + 8'd1;
                        addr_q <= addr_nxt;
                    end
                end
                RD_DATA: begin
                    if (s.rready && !last) begin
                        cnt    <= cnt + 8'd1;
                        addr_q <= addr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        s.awready  = 1'b0;
        s.wready   = 1'b0;
        s.bvalid   = 1'b0;
        s.bid      = '0;
        s.bresp    = 2'b00;
        s.arready  = 1'b0;
        s.rvalid   = 1'b0;
        s.rid      = '0;
        s.rdata    = '0;
        s.rresp    = 2'b00;
        s.rlast    = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                if (go_rd)
                    state_nxt = AR_ACC;
                else if (go_wr)
                    state_nxt = AW_ACC;
            end
            AW_ACC: begin
                s.awready = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                s.wready = 1'b1;
                if (s.wvalid) begin
                    if (!err_q) begin
                        sram_cs    = 1'b1;
                        sram_we    = s.wstrb;
                        sram_wdata = s.wdata;
                        sram_addr  = addr_q[MEM_ADDR_WIDTH+LB-1:LB];
                    end
                    if (last)
                        state_nxt = WRESP;
                end
            end
            WRESP: begin
                s.bvalid = 1'b1;
                s.bid    = id_q;
                s.bresp  = err_q ? 2'b10 : 2'b00;
                if (s.bready)
                    state_nxt = IDLE;
            end
            AR_ACC: begin
                s.arready = 1'b1;
                state_nxt = RD_REQ;
            end
            RD_REQ: begin
                if (!err_q) begin
                    sram_cs   = 1'b1;
                    sram_addr = addr_q[MEM_ADDR_WIDTH+LB-1:LB];
                end
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // First cycle shows the SRAM output directly; later cycles
                // hold the captured copy so rdata is stable across stalls.
                s.rvalid = 1'b1;
                s.rid    = id_q;
                s.rdata  = err_q ? '0 : (rd_fresh ? sram_rdata : rdata_q);
                s.rresp  = err_q ? 2'b10 : 2'b00;
                s.rlast  = last;
                if (s.rready)
                    state_nxt = last ? IDLE : RD_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave with a behavioural
// single-port SRAM (1-cycle read latency) and a log of written word addresses.
module tb_axi_sram_slave;
    localparam int IDW = 10;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_intf #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    logic           sram_cs;
    logic [3:0]     sram_we;
    logic [MAW-1:0] sram_addr;
    logic [31:0]    sram_wdata;
    logic [31:0]    sram_rdata;

    axi_sram_slave #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk(clk), .rst(rst), .s(axi),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM model; read port outputs noise when not reading.
    logic [31:0]    mem [0:(1<<MAW)-1];
    int unsigned    cs_count = 0;
    logic [MAW-1:0] wlog [$];
    always @(posedge clk) begin
        if (sram_cs)
            cs_count <= cs_count + 1;
        if (sram_cs && sram_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b])
                    mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            wlog.push_back(sram_addr);
        end
        if (sram_cs && sram_we == 4'h0)
            sram_rdata <= mem[sram_addr];
        else
            sram_rdata <= $urandom;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return axi.awready;
            1:       return axi.arready;
            2:       return axi.wready;
            3:       return axi.bvalid;
            default: return axi.rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag);
        int n = 0;
        while (sig(w) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " handshake"}, 64'(sig(w)), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ctl"}, 64'({axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp,
                                  axi.arready, axi.rvalid, axi.rid, axi.rresp, axi.rlast,
                                  sram_cs, sram_we}), 64'(0));
        check({tag, " rdata"}, 64'(axi.rdata), 64'(0));
    endtask

    task automatic set_aw(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
        axi.awburst = burst; axi.awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1;
    endtask

    task automatic w_beats_and_b(input string tag, input logic [9:0] id, input logic [7:0] len,
                                 input logic [31:0] d [4], input logic [3:0] strb,
                                 input logic [1:0] exp_resp);
        for (int i = 0; i <= int'(len); i++) begin
            axi.wvalid = 1'b1; axi.wdata = d[i]; axi.wstrb = strb; axi.wlast = (i == int'(len));
            wait_sig(2, {tag, " w"});
            tick();
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        axi.bready = 1'b1;
        wait_sig(3, {tag, " b"});
        check({tag, " bid"}, 64'(axi.bid), 64'(id));
        check({tag, " bresp"}, 64'(axi.bresp), 64'(exp_resp));
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [9:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] d [4], input logic [3:0] strb,
                             input logic [1:0] exp_resp);
        set_aw(id, addr, len, size, burst);
        wait_sig(0, {tag, " aw"});
        tick();
        axi.awvalid = 1'b0;
        w_beats_and_b(tag, id, len, d, strb, exp_resp);
    endtask

    task automatic axi_read(input string tag, input logic [9:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d [4], input logic [1:0] exp_resp, input bit stall);
        set_ar(id, addr, len, size, burst);
        wait_sig(1, {tag, " ar"});
        tick();
        axi.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wait_sig(4, {tag, " r"});
            if (stall) begin
                repeat (3) begin
                    check({tag, " stall rdata"}, 64'(axi.rdata), 64'(d[i]));
                    tick();
                end
                check({tag, " stall rvalid"}, 64'(axi.rvalid), 64'(1));
            end
            check({tag, " rdata"}, 64'(axi.rdata), 64'(d[i]));
            check({tag, " rid"}, 64'(axi.rid), 64'(id));
            check({tag, " rresp"}, 64'(axi.rresp), 64'(exp_resp));
            check({tag, " rlast"}, 64'(axi.rlast), 64'(i == int'(len)));
            axi.rready = 1'b1;
            tick();
            axi.rready = 1'b0;
        end
        check({tag, " rvalid after last"}, 64'(axi.rvalid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          base;
        int unsigned cs0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        rst = 1'b1;
        tick(); tick();
        check_zero("reset");
        rst = 1'b0;

        // 1. single write
        axi_write("t1", 10'h155, 32'h10, 8'd0, 3'd2, 2'b01, '{32'hDEADBEEF, 0, 0, 0}, 4'hF, 2'b00);
        check("t1 mem[4]", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);

        // 2. INCR burst read (memory loaded by an INCR write burst first)
        axi_write("t2 load", 10'h001, 32'h10, 8'd3, 3'd2, 2'b01,
                  '{32'h11, 32'h22, 32'h33, 32'h44}, 4'hF, 2'b00);
        axi_read("t2", 10'h2A3, 32'h10, 8'd3, 3'd2, 2'b01,
                 '{32'h11, 32'h22, 32'h33, 32'h44}, 2'b00, 1'b0);
        axi_read("t2 stall", 10'h3FF, 32'h10, 8'd3, 3'd2, 2'b01,
                 '{32'h11, 32'h22, 32'h33, 32'h44}, 2'b00, 1'b1);
        axi_read("fixed", 10'h004, 32'h14, 8'd1, 3'd2, 2'b00,
                 '{32'h22, 32'h22, 0, 0}, 2'b00, 1'b0);

        // 3. WRAP write: 0x38 -> words 14,15,12,13
        base = wlog.size();
        axi_write("t3", 10'h033, 32'h38, 8'd3, 3'd2, 2'b10,
                  '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'hF, 2'b00);
        check("t3 nwrites", 64'(wlog.size() - base), 64'(4));
        check("t3 order0", 64'(wlog[base+0]), 64'(14));
        check("t3 order1", 64'(wlog[base+1]), 64'(15));
        check("t3 order2", 64'(wlog[base+2]), 64'(12));
        check("t3 order3", 64'(wlog[base+3]), 64'(13));
        check("t3 mem12", 64'(mem[12]), 64'hA2);

        // 4. strobe write into a zeroed word
        axi_write("t4 clr", 10'h040, 32'h0, 8'd0, 3'd2, 2'b01, '{32'h0, 0, 0, 0}, 4'hF, 2'b00);
        axi_write("t4", 10'h041, 32'h0, 8'd0, 3'd2, 2'b01, '{32'hAABBCCDD, 0, 0, 0}, 4'h2, 2'b00);
        axi_read("t4 rd", 10'h042, 32'h0, 8'd0, 3'd2, 2'b01, '{32'h0000CC00, 0, 0, 0}, 2'b00, 1'b0);

        // 5. reserved burst type: no SRAM access, SLVERR, zero data
        cs0 = cs_count;
        axi_write("t5 wr", 10'h050, 32'h10, 8'd1, 3'd2, 2'b11, '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0},
                  4'hF, 2'b10);
        axi_read("t5 rd", 10'h051, 32'h10, 8'd1, 3'd2, 2'b11, '{0, 0, 0, 0}, 2'b10, 1'b0);
        check("t5 sram untouched", 64'(cs_count), 64'(cs0));
        check("t5 mem4 intact", 64'(mem[4]), 64'h11);

        // 6. simultaneous AW/AR out of reset: read first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_aw(10'h060, 32'h40, 8'd0, 3'd2, 2'b01);
        set_ar(10'h061, 32'h10, 8'd0, 3'd2, 2'b01);
        tick();
        check("t6 arready first", 64'(axi.arready), 64'(1));
        check("t6 awready held", 64'(axi.awready), 64'(0));
        tick();
        axi.arvalid = 1'b0;
        wait_sig(4, "t6 r");
        check("t6 rdata", 64'(axi.rdata), 64'h11);
        check("t6 rid", 64'(axi.rid), 64'h061);
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        wait_sig(0, "t6 aw");
        check("t6 arready low", 64'(axi.arready), 64'(0));
        tick();
        axi.awvalid = 1'b0;
        w_beats_and_b("t6 wr", 10'h060, 8'd0, '{32'h12345678, 0, 0, 0}, 4'hF, 2'b00);
        check("t6 mem16", 64'(mem[16]), 64'h12345678);

        // reset mid write burst
        set_aw(10'h070, 32'h80, 8'd3, 3'd2, 2'b01);
        wait_sig(0, "rst aw");
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b1; axi.wdata = 32'h5555AAAA; axi.wstrb = 4'hF;
        wait_sig(2, "rst w");
        tick();
        check("rst mid cs", 64'(sram_cs), 64'(1));
        rst = 1'b1;
        tick();
        check_zero("rst mid");
        rst = 1'b0;
        axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        repeat (4) tick();
        check("rst no bresp", 64'(axi.bvalid), 64'(0));
        axi.bready = 1'b0;
        axi_read("post rst", 10'h071, 32'h40, 8'd0, 3'd2, 2'b01, '{32'h12345678, 0, 0, 0},
                 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
